// File: rtl/timer_6801.sv
// -----------------------------------------------------------------------------
// timer_6801
// 6801-compatible programmable timer: 16-bit free-running counter (FRC) with
// output compare, input capture and overflow detection, plus the MCU register
// window used by cpu01 (offsets 0..6 inside the decoded 0x08-0x0E range).
//
// Ports
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous reset, active low
//   hold      global stall: all state frozen, bus accesses have no effect
//   cs        timer register window selected
//   vma       valid memory address from cpu01
//   rw        1 = read, 0 = write
//   addr[2:0] 0=TCSR 1=FRC_H 2=FRC_L 3=OCR_H 4=OCR_L 5=ICR_H 6=ICR_L 7=unused
//   data_in   write data
//   data_out  combinational read data, 8'h00 when not (cs & vma & rw)
//   tin       input-capture pin (asynchronous)
//   tout      output-compare pin
//   irq_icf   ICF & EICI
//   irq_ocf   OCF & EOCI
//   irq_tof   TOF & ETOI
//
// Parameters
//   PRESCALE   clk cycles per FRC increment (1..256)
//   FRC_PRESET value loaded into the FRC by any write to FRC_H
// -----------------------------------------------------------------------------
module timer_6801 #(
  parameter int          PRESCALE   = 1,
  parameter logic [15:0] FRC_PRESET = 16'hFFF8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       cs,
  input  logic       vma,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       tin,
  output logic       tout,
  output logic       irq_icf,
  output logic       irq_ocf,
  output logic       irq_tof
);

  localparam logic [2:0] A_TCSR = 3'd0;
  localparam logic [2:0] A_FRCH = 3'd1;
  localparam logic [2:0] A_FRCL = 3'd2;
  localparam logic [2:0] A_OCRH = 3'd3;
  localparam logic [2:0] A_OCRL = 3'd4;
  localparam logic [2:0] A_ICRH = 3'd5;
  localparam logic [2:0] A_ICRL = 3'd6;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  // Flag vector layout matches TCSR bits 7..5: [2]=ICF [1]=OCF [0]=TOF.
  // Control layout matches TCSR bits 4..0: EICI EOCI ETOI IEDG OLVL.
  logic [15:0] frc_reg, frc_next;
  logic [15:0] ocr_reg, ocr_next;
  logic [15:0] icr_reg, icr_next;
  logic [7:0]  latch_reg, latch_next;
  logic [7:0]  presc_reg, presc_next;
  logic [4:0]  ctrl_reg, ctrl_next;
  logic [2:0]  flag_reg, flag_next;
  logic [2:0]  arm_reg, arm_next;
  logic [2:0]  flag_set, flag_clr;
  logic [2:0]  sync_reg, sync_next;
  logic        tout_reg, tout_next;
  logic        cap_block_reg, cap_block_next;
  logic        oc_inh_reg, oc_inh_next;
  logic        match_pend_reg, match_pend_next;

  logic acc, rd, wr;
  logic rd_tcsr, rd_frch, rd_icrh, rd_icrl;
  logic wr_tcsr, wr_frch, wr_ocrh, wr_ocrl;
  logic tick, frc_changed, overflow, oc_match, tin_edge, capture;

  // ---------------------------------------------------------------------------
  // Bus decode. Side effects only happen on edges where hold is low.
  // ---------------------------------------------------------------------------
  assign acc = cs & vma & ~hold;
  assign rd  = acc & rw;
  assign wr  = acc & ~rw;

  assign rd_tcsr = rd & (addr == A_TCSR);
  assign rd_frch = rd & (addr == A_FRCH);
  assign rd_icrh = rd & (addr == A_ICRH);
  assign rd_icrl = rd & (addr == A_ICRL);
  assign wr_tcsr = wr & (addr == A_TCSR);
  assign wr_frch = wr & (addr == A_FRCH);
  assign wr_ocrh = wr & (addr == A_OCRH);
  assign wr_ocrl = wr & (addr == A_OCRL);

  // ---------------------------------------------------------------------------
  // Prescaler and free-running counter
  // ---------------------------------------------------------------------------
  assign tick = (presc_reg == PRESC_LAST);

  always_comb begin
    presc_next  = tick ? 8'd0 : presc_reg + 8'd1;
    frc_next    = frc_reg;
    frc_changed = 1'b0;
    overflow    = 1'b0;
    if (wr_frch) begin
      // A preset load restarts the prescale period and takes priority over
      // a coincident increment; it never counts as an overflow.
      frc_next    = FRC_PRESET;
      presc_next  = 8'd0;
      frc_changed = 1'b1;
    end else if (tick) begin
      frc_next    = frc_reg + 16'd1;
      frc_changed = 1'b1;
      overflow    = (frc_reg == 16'hFFFF);
    end
  end

  // FRC_H read snapshots the low byte so a following FRC_L read is coherent.
  assign latch_next = rd_frch ? frc_reg[7:0] : latch_reg;

  // ---------------------------------------------------------------------------
  // Output compare
  // ---------------------------------------------------------------------------
  always_comb begin
    ocr_next    = ocr_reg;
    oc_inh_next = oc_inh_reg;
    if (wr_ocrh) begin
      ocr_next[15:8] = data_in;
      oc_inh_next    = 1'b1;
    end
    if (wr_ocrl) begin
      ocr_next[7:0] = data_in;
      oc_inh_next   = 1'b0;
    end
  end

  // The comparison is only looked at once per new FRC value (or once after a
  // completed OCR update), so sitting on a matching value does not re-raise
  // OCF after software has cleared it.
  assign match_pend_next = frc_changed | wr_ocrl;
  assign oc_match        = match_pend_reg & ~oc_inh_reg & (frc_reg == ocr_reg);
  assign tout_next       = oc_match ? ctrl_reg[0] : tout_reg;

  // ---------------------------------------------------------------------------
  // Input capture: two synchroniser flops then one history flop for edges
  // ---------------------------------------------------------------------------
  assign sync_next = {sync_reg[1:0], tin};
  assign tin_edge  = ctrl_reg[1] ? ( sync_reg[1] & ~sync_reg[2])
                                 : (~sync_reg[1] &  sync_reg[2]);

  // Capture is blocked from the ICR_H read edge until the ICR_L read edge
  // (inclusive) so the two bytes always come from the same capture.
  assign capture   = tin_edge & ~cap_block_reg & ~rd_icrh;
  assign icr_next  = capture ? frc_reg : icr_reg;

  always_comb begin
    cap_block_next = cap_block_reg;
    if (rd_icrh) begin
      cap_block_next = 1'b1;
    end else if (rd_icrl) begin
      cap_block_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control bits and status flags
  // ---------------------------------------------------------------------------
  assign ctrl_next = wr_tcsr ? data_in[4:0] : ctrl_reg;

  assign flag_set = {capture, oc_match, overflow};
  assign flag_clr = {rd_icrh, wr_ocrh | wr_ocrl, rd_frch};

  // Each flag is cleared by its own access only after a TCSR read has seen it
  // set. A set on the same edge as a clear wins, but still consumes the arm.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_flag
      assign flag_next[gi] = flag_set[gi] |
                             (flag_reg[gi] & ~(arm_reg[gi] & flag_clr[gi]));
      assign arm_next[gi]  = (arm_reg[gi] & flag_clr[gi]) ? 1'b0 :
                             (rd_tcsr & flag_reg[gi])     ? 1'b1 :
                                                            arm_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frc_reg        <= 16'h0000;
      ocr_reg        <= 16'hFFFF;
      icr_reg        <= 16'h0000;
      latch_reg      <= 8'h00;
      presc_reg      <= 8'd0;
      ctrl_reg       <= 5'd0;
      flag_reg       <= 3'd0;
      arm_reg        <= 3'd0;
      sync_reg       <= 3'd0;
      tout_reg       <= 1'b0;
      cap_block_reg  <= 1'b0;
      oc_inh_reg     <= 1'b0;
      match_pend_reg <= 1'b0;
    end else if (!hold) begin
      frc_reg        <= frc_next;
      ocr_reg        <= ocr_next;
      icr_reg        <= icr_next;
      latch_reg      <= latch_next;
      presc_reg      <= presc_next;
      ctrl_reg       <= ctrl_next;
      flag_reg       <= flag_next;
      arm_reg        <= arm_next;
      sync_reg       <= sync_next;
      tout_reg       <= tout_next;
      cap_block_reg  <= cap_block_next;
      oc_inh_reg     <= oc_inh_next;
      match_pend_reg <= match_pend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out = 8'h00;
    if (cs & vma & rw) begin
      case (addr)
        A_TCSR:  data_out = {flag_reg, ctrl_reg};
        A_FRCH:  data_out = frc_reg[15:8];
        A_FRCL:  data_out = latch_reg;
        A_OCRH:  data_out = ocr_reg[15:8];
        A_OCRL:  data_out = ocr_reg[7:0];
        A_ICRH:  data_out = icr_reg[15:8];
        A_ICRL:  data_out = icr_reg[7:0];
        default: data_out = 8'h00;
      endcase
    end
  end

  assign tout    = tout_reg;
  assign irq_icf = flag_reg[2] & ctrl_reg[4];
  assign irq_ocf = flag_reg[1] & ctrl_reg[3];
  assign irq_tof = flag_reg[0] & ctrl_reg[2];

endmodule

// File: tb/tb_timer_6801.sv
// -----------------------------------------------------------------------------
// tb_timer_6801
// Self-checking bench for timer_6801 (default parameters: PRESCALE=1,
// FRC_PRESET=FFF8). The expected FRC value is derived arithmetically from the
// number of un-stalled clock edges since the last reset or preset load.
// -----------------------------------------------------------------------------
module tb_timer_6801;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       cs = 1'b0;
  logic       vma = 1'b0;
  logic       rw = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tin = 1'b0;
  logic       tout, irq_icf, irq_ocf, irq_tof;

  int vec = 0;
  int errs = 0;

  // Reference FRC: preset value plus count of active edges since it was set.
  int unsigned act_edges = 0;
  int unsigned edge_base = 0;
  logic [15:0] frc_base  = 16'h0000;

  logic [7:0]  d;
  logic [15:0] f;

  timer_6801 dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .cs(cs), .vma(vma), .rw(rw),
    .addr(addr), .data_in(data_in), .data_out(data_out), .tin(tin),
    .tout(tout), .irq_icf(irq_icf), .irq_ocf(irq_ocf), .irq_tof(irq_tof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && !hold) act_edges++;

  function automatic logic [15:0] frc_now();
    logic [15:0] dn;
    dn = 16'(act_edges - edge_base);
    return frc_base + dn;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] dv, output logic [15:0] fv);
    @(negedge clk);
    cs = 1'b1; vma = 1'b1; rw = 1'b1; addr = a;
    #1;
    dv = data_out;
    fv = frc_now();
    @(posedge clk);
    #1;
    cs = 1'b0; vma = 1'b0;
    $display("rd  off=%0d data=%02h", a, dv);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] dv);
    @(negedge clk);
    cs = 1'b1; vma = 1'b1; rw = 1'b0; addr = a; data_in = dv;
    @(posedge clk);
    #1;
    cs = 1'b0; vma = 1'b0; rw = 1'b1;
    $display("wr  off=%0d data=%02h", a, dv);
  endtask

  task automatic frc_preset();
    bus_wr(3'd1, 8'($urandom));
    frc_base  = 16'hFFF8;
    edge_base = act_edges;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b0; cs = 1'b0; vma = 1'b0; rw = 1'b1; tin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    frc_base  = 16'h0000;
    edge_base = act_edges;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    bus_wr(3'd0, 8'h04);
    frc_preset();
    idle(8);
    vec++; if (irq_tof !== 1'b1) begin errs++; $display("FAIL pre_rst_tof got=%b exp=1", irq_tof); end
    #3 rst_n = 1'b0;
    #1;
    vec++; if (irq_tof !== 1'b0) begin errs++; $display("FAIL async_rst_tof got=%b exp=0", irq_tof); end
    vec++; if (tout !== 1'b0) begin errs++; $display("FAIL async_rst_tout got=%b exp=0", tout); end
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    frc_base  = 16'h0000;
    edge_base = act_edges;
    idle(16);
    bus_rd(3'd1, d, f);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_frch got=%02h exp=00", d); end
    bus_rd(3'd2, d, f);
    vec++; if (d !== 8'h10) begin errs++; $display("FAIL rst_frcl got=%02h exp=10", d); end
    bus_rd(3'd0, d, f);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_tcsr got=%02h exp=00", d); end
    bus_rd(3'd3, d, f);
    vec++; if (d !== 8'hFF) begin errs++; $display("FAIL rst_ocrh got=%02h exp=FF", d); end
    bus_rd(3'd4, d, f);
    vec++; if (d !== 8'hFF) begin errs++; $display("FAIL rst_ocrl got=%02h exp=FF", d); end
    bus_rd(3'd5, d, f);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_icrh got=%02h exp=00", d); end
    bus_rd(3'd6, d, f);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_icrl got=%02h exp=00", d); end
    vec++;
    if ({tout, irq_icf, irq_ocf, irq_tof} !== 4'b0000) begin
      errs++; $display("FAIL rst_outs got=%b exp=0000", {tout, irq_icf, irq_ocf, irq_tof});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_frc_read();
    logic [7:0] latch_exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 60));
      if (i == 2) bus_wr(3'd2, 8'($urandom));   // FRC_L writes have no effect
      bus_rd(3'd1, d, f);
      latch_exp = f[7:0];
      vec++; if (d !== f[15:8]) begin errs++; $display("FAIL frch_%0d got=%02h exp=%02h", i, d, f[15:8]); end
      idle($urandom_range(0, 20));
      bus_rd(3'd2, d, f);
      vec++; if (d !== latch_exp) begin errs++; $display("FAIL frcl_%0d got=%02h exp=%02h", i, d, latch_exp); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_output_compare();
    logic        olvl, prev_tout;
    logic [15:0] target;
    int          n;
    do_reset();
    prev_tout = 1'b0;
    for (int it = 0; it < 3; it++) begin
      olvl = (it == 0) ? 1'b1 : 1'($urandom);
      frc_preset();
      target = 16'hFFF8 + 16'($urandom_range(20, 120));
      bus_wr(3'd0, {7'b0000100, olvl});
      bus_wr(3'd3, target[15:8]);
      bus_wr(3'd4, target[7:0]);
      n = int'(16'(target - frc_now()));
      idle(n);
      // FRC now equals OCR; the flag and pin follow on the next edge.
      vec++; if (irq_ocf !== 1'b0) begin errs++; $display("FAIL oc_early_%0d got=%b exp=0", it, irq_ocf); end
      vec++; if (tout !== prev_tout) begin errs++; $display("FAIL tout_early_%0d got=%b exp=%b", it, tout, prev_tout); end
      idle(1);
      vec++; if (irq_ocf !== 1'b1) begin errs++; $display("FAIL oc_set_%0d got=%b exp=1", it, irq_ocf); end
      vec++; if (tout !== olvl) begin errs++; $display("FAIL tout_set_%0d got=%b exp=%b", it, tout, olvl); end
      prev_tout = olvl;
      if (it == 0) begin
        // Not armed yet: an OCR write must leave OCF set.
        bus_wr(3'd3, target[15:8]);
        vec++; if (irq_ocf !== 1'b1) begin errs++; $display("FAIL oc_unarmed got=%b exp=1", irq_ocf); end
        bus_wr(3'd4, target[7:0]);
      end
      bus_rd(3'd0, d, f);
      // The FRC wrapped on its way from FFF8 to OCR, so TOF is set as well.
      vec++; if (d !== {7'b0110100, olvl}) begin errs++; $display("FAIL oc_tcsr_%0d got=%02h exp=%02h", it, d, {7'b0110100, olvl}); end
      bus_wr(3'd3, target[15:8]);
      vec++; if (irq_ocf !== 1'b0) begin errs++; $display("FAIL oc_clr_%0d got=%b exp=0", it, irq_ocf); end
      bus_wr(3'd4, target[7:0]);
      vec++; if (tout !== olvl) begin errs++; $display("FAIL tout_hold_%0d got=%b exp=%b", it, tout, olvl); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // With OCR left at FFFF, the FRC passing FFFF also raises OCF, so TCSR reads
  // 64 (OCF, TOF, ETOI) whenever an overflow has just happened here.
  task automatic test_overflow();
    do_reset();
    bus_wr(3'd0, 8'h04);
    frc_preset();
    idle(7);
    vec++; if (irq_tof !== 1'b0) begin errs++; $display("FAIL tof_early got=%b exp=0", irq_tof); end
    idle(1);
    vec++; if (irq_tof !== 1'b1) begin errs++; $display("FAIL tof_set got=%b exp=1", irq_tof); end
    bus_rd(3'd0, d, f);
    vec++; if (d !== 8'h64) begin errs++; $display("FAIL tof_tcsr got=%02h exp=64", d); end
    bus_rd(3'd1, d, f);
    vec++; if (d !== f[15:8]) begin errs++; $display("FAIL tof_frch got=%02h exp=%02h", d, f[15:8]); end
    vec++; if (irq_tof !== 1'b0) begin errs++; $display("FAIL tof_clr got=%b exp=0", irq_tof); end
    // Set and armed clear on the same edge: set wins and the arm is spent.
    frc_preset();
    idle(8);
    bus_rd(3'd0, d, f);
    vec++; if (d !== 8'h64) begin errs++; $display("FAIL tof_tcsr2 got=%02h exp=64", d); end
    frc_preset();
    idle(7);
    bus_rd(3'd1, d, f);
    vec++; if (d !== 8'hFF) begin errs++; $display("FAIL tof_coinc_frch got=%02h exp=FF", d); end
    vec++; if (irq_tof !== 1'b1) begin errs++; $display("FAIL tof_setwins got=%b exp=1", irq_tof); end
    bus_rd(3'd1, d, f);
    vec++; if (irq_tof !== 1'b1) begin errs++; $display("FAIL tof_arm_spent got=%b exp=1", irq_tof); end
    bus_rd(3'd0, d, f);
    bus_rd(3'd1, d, f);
    vec++; if (irq_tof !== 1'b0) begin errs++; $display("FAIL tof_clr2 got=%b exp=0", irq_tof); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_input_capture();
    logic [15:0] exp_icr;
    logic        iedg;
    do_reset();
    bus_wr(3'd0, 8'h12);                 // EICI, IEDG=rising
    idle($urandom_range(1, 40));
    @(negedge clk); tin = 1'b1;
    repeat (2) @(posedge clk); #1;
    exp_icr = frc_now();                 // FRC when the synchronised edge is seen
    vec++; if (irq_icf !== 1'b0) begin errs++; $display("FAIL ic_early got=%b exp=0", irq_icf); end
    idle(1);
    vec++; if (irq_icf !== 1'b1) begin errs++; $display("FAIL ic_set got=%b exp=1", irq_icf); end
    bus_rd(3'd0, d, f);
    vec++; if (d !== 8'h92) begin errs++; $display("FAIL ic_tcsr got=%02h exp=92", d); end
    bus_rd(3'd5, d, f);
    vec++; if (d !== exp_icr[15:8]) begin errs++; $display("FAIL ic_icrh got=%02h exp=%02h", d, exp_icr[15:8]); end
    vec++; if (irq_icf !== 1'b0) begin errs++; $display("FAIL ic_clr got=%b exp=0", irq_icf); end
    bus_rd(3'd6, d, f);
    vec++; if (d !== exp_icr[7:0]) begin errs++; $display("FAIL ic_icrl got=%02h exp=%02h", d, exp_icr[7:0]); end
    // Falling edge with IEDG=1 is ignored.
    @(negedge clk); tin = 1'b0;
    idle(5);
    vec++; if (irq_icf !== 1'b0) begin errs++; $display("FAIL ic_fall got=%b exp=0", irq_icf); end
    // Rising edge while ICR is held between ICR_H and ICR_L reads is lost.
    bus_rd(3'd5, d, f);
    vec++; if (d !== exp_icr[15:8]) begin errs++; $display("FAIL ic_hold_icrh got=%02h exp=%02h", d, exp_icr[15:8]); end
    @(negedge clk); tin = 1'b1;
    idle(5);
    bus_rd(3'd6, d, f);
    vec++; if (d !== exp_icr[7:0]) begin errs++; $display("FAIL ic_hold_icrl got=%02h exp=%02h", d, exp_icr[7:0]); end
    idle(3);
    vec++; if (irq_icf !== 1'b0) begin errs++; $display("FAIL ic_lost got=%b exp=0", irq_icf); end
    // Random polarity captures.
    for (int i = 0; i < 4; i++) begin
      iedg = 1'($urandom);
      bus_wr(3'd0, {6'b000100, iedg, 1'b0});
      @(negedge clk); tin = ~iedg;
      idle(6 + $urandom_range(0, 40));
      @(negedge clk); tin = iedg;
      repeat (2) @(posedge clk); #1;
      exp_icr = frc_now();
      idle(1);
      vec++; if (irq_icf !== 1'b1) begin errs++; $display("FAIL icr_set_%0d got=%b exp=1", i, irq_icf); end
      bus_rd(3'd0, d, f);
      bus_rd(3'd5, d, f);
      vec++; if (d !== exp_icr[15:8]) begin errs++; $display("FAIL icr_h_%0d got=%02h exp=%02h", i, d, exp_icr[15:8]); end
      bus_rd(3'd6, d, f);
      vec++; if (d !== exp_icr[7:0]) begin errs++; $display("FAIL icr_l_%0d got=%02h exp=%02h", i, d, exp_icr[7:0]); end
      vec++; if (irq_icf !== 1'b0) begin errs++; $display("FAIL icr_clr_%0d got=%b exp=0", i, irq_icf); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hold();
    logic [15:0] frozen;
    do_reset();
    bus_wr(3'd0, 8'h04);
    frc_preset();
    idle(3);                              // FRC = FFFB
    frozen = frc_now();
    @(negedge clk);
    hold = 1'b1; cs = 1'b1; vma = 1'b1; rw = 1'b0; addr = 3'd0; data_in = 8'h1F;
    repeat (5) @(posedge clk); #1;
    addr = 3'd1;                          // attempted FRC_H preset, must be ignored
    repeat (5) @(posedge clk); #1;
    rw = 1'b1; addr = 3'd1;
    #1;
    vec++; if (data_out !== frozen[15:8]) begin errs++; $display("FAIL hold_frch got=%02h exp=%02h", data_out, frozen[15:8]); end
    vec++; if (irq_tof !== 1'b0) begin errs++; $display("FAIL hold_tof got=%b exp=0", irq_tof); end
    @(negedge clk);
    hold = 1'b0; cs = 1'b0; vma = 1'b0;
    $display("hold released after 10 clocks");
    idle(4);
    vec++; if (irq_tof !== 1'b0) begin errs++; $display("FAIL hold_resume_early got=%b exp=0", irq_tof); end
    idle(1);
    vec++; if (irq_tof !== 1'b1) begin errs++; $display("FAIL hold_resume_tof got=%b exp=1", irq_tof); end
    bus_rd(3'd0, d, f);
    vec++; if (d !== 8'h64) begin errs++; $display("FAIL hold_tcsr got=%02h exp=64", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_misc();
    do_reset();
    bus_wr(3'd0, 8'h05);
    bus_wr(3'd7, 8'hFF);
    bus_rd(3'd7, d, f);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL off7_rd got=%02h exp=00", d); end
    bus_rd(3'd0, d, f);
    vec++; if (d !== 8'h05) begin errs++; $display("FAIL misc_tcsr got=%02h exp=05", d); end
    @(negedge clk);
    cs = 1'b1; vma = 1'b0; rw = 1'b1; addr = 3'd0;
    #1;
    vec++; if (data_out !== 8'h00) begin errs++; $display("FAIL novma_rd got=%02h exp=00", data_out); end
    cs = 1'b0; vma = 1'b1;
    #1;
    vec++; if (data_out !== 8'h00) begin errs++; $display("FAIL nocs_rd got=%02h exp=00", data_out); end
    vma = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frc_read();
    test_output_compare();
    test_overflow();
    test_input_capture();
    test_hold();
    test_misc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached after %0d vectors", vec);
    $fatal(1, "watchdog");
  end

endmodule
